// File: rtl/mem_io_pkg.sv
// Shared types for the MEM-stage RAM / I/O arbiter.
// Optional perf counters: MEM_IO_ARB_PERF_EN.
package mem_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CPU,
    DBG,
    DBG_LOCK
  } arb_state_e;

  localparam int   IO_SEL_BIT = 7;
  localparam logic OWNER_CPU  = 1'b0;
  localparam logic OWNER_DBG  = 1'b1;

  function automatic logic [31:0] sat_inc32(
    input logic [31:0] v
  );
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_io_arbiter_if.sv
// Requester and RAM/I/O bus signals of the MEM-stage arbiter.
// Perf outputs (MEM_IO_ARB_PERF_EN) are plain ports on the top.
interface mem_io_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;

  logic          dbg_req;
  logic          dbg_lock;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_rvalid;

  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          mem_we;
  logic          io_we;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] io_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dbg_req, dbg_lock, dbg_we,
    output dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    input  bus_addr, bus_wdata, mem_we, io_we,
    output mem_rdata, io_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dbg_req, dbg_lock, dbg_we,
    input  dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    output bus_addr, bus_wdata, mem_we, io_we,
    input  mem_rdata, io_rdata
  );

endinterface

// File: rtl/mem_io_arbiter_rr_arb2.sv
// Two-way round-robin grant with dbg lock and forced cpu release.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic lock,
  input  logic force_rel,
  output logic gnt0,
  output logic gnt1
);

  logic both;
  logic any;

  assign both = req0 & req1;
  assign any  = req0 | req1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      force_rel: gnt0 = 1'b1;
      (~force_rel & lock): gnt1 = 1'b1;
      (~force_rel & ~lock & both): begin
        gnt0 = last;
        gnt1 = ~last;
      end
      (~force_rel & ~lock & ~both & any): begin
        gnt0 = req0;
        gnt1 = req1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_io_arbiter.sv
// Shares MEM-stage RAM / I/O between the pipeline and the debug port.
// Define MEM_IO_ARB_PERF_EN to add stall / dbg-grant perf counters.
module mem_io_arbiter
  import mem_io_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic            clock,
  input  logic            reset,
  mem_io_arbiter_if.slave bus
`ifdef MEM_IO_ARB_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_dbg_cnt
`endif
);

  localparam logic [7:0] MAXB = 8'(MAX_BURST);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          lock, force_rel;
  logic          cpu_raw, dbg_raw;
  logic          cpu_gnt, dbg_gnt, any_gnt;
  logic          gnt_we, stall;
  logic [AW-1:0] addr_w, addr_q;
  logic [DW-1:0] wdata_w, wdata_q;

  logic          rd_valid_q, rd_owner_q, rd_sel_q;
  logic          cpu_rv, dbg_rv;
  logic [DW-1:0] ret_data;
  logic [DW-1:0] cpu_rdata_w, cpu_rdata_q;
  logic [DW-1:0] dbg_rdata_w, dbg_rdata_q;

  assign lock = (state_q == DBG_LOCK)
              & bus.dbg_req & bus.dbg_lock;
  assign force_rel = lock & bus.cpu_req
                   & (cnt_q >= MAXB);

  rr_arb2 u_rr (
    .req0      (bus.cpu_req),
    .req1      (bus.dbg_req),
    .last      (last_q),
    .lock      (lock),
    .force_rel (force_rel),
    .gnt0      (cpu_raw),
    .gnt1      (dbg_raw)
  );

  // Reset cycle must neither grant nor write.
  assign cpu_gnt = cpu_raw & ~reset;
  assign dbg_gnt = dbg_raw & ~reset;
  assign any_gnt = cpu_gnt | dbg_gnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= OWNER_DBG;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    last_d  = last_q;
    cnt_d   = '0;
    unique case (1'b1)
      dbg_gnt: begin
        state_d = bus.dbg_lock ? DBG_LOCK : DBG;
        last_d  = OWNER_DBG;
        if (bus.dbg_lock) begin
          if (state_q != DBG_LOCK)
            cnt_d = 8'd1;
          else if (cnt_q >= MAXB)
            cnt_d = cnt_q;
          else
            cnt_d = cnt_q + 8'd1;
        end
      end
      cpu_gnt: begin
        state_d = CPU;
        last_d  = OWNER_CPU;
      end
      default: ;
    endcase
  end

  always_comb begin
    addr_w  = addr_q;
    wdata_w = wdata_q;
    gnt_we  = 1'b0;
    unique case (1'b1)
      reset: begin
        addr_w  = '0;
        wdata_w = '0;
      end
      cpu_gnt: begin
        addr_w  = bus.cpu_addr;
        wdata_w = bus.cpu_wdata;
        gnt_we  = bus.cpu_we;
      end
      dbg_gnt: begin
        addr_w  = bus.dbg_addr;
        wdata_w = bus.dbg_wdata;
        gnt_we  = bus.dbg_we;
      end
      default: ;
    endcase
  end

  assign stall    = bus.cpu_req & ~cpu_gnt & ~reset;
  assign ret_data = rd_sel_q ? bus.io_rdata
                             : bus.mem_rdata;
  assign cpu_rv = rd_valid_q & ~reset
                & (rd_owner_q == OWNER_CPU);
  assign dbg_rv = rd_valid_q & ~reset
                & (rd_owner_q == OWNER_DBG);
  assign cpu_rdata_w = cpu_rv ? ret_data : cpu_rdata_q;
  assign dbg_rdata_w = dbg_rv ? ret_data : dbg_rdata_q;

  assign bus.cpu_stall  = stall;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.bus_addr   = addr_w;
  assign bus.bus_wdata  = wdata_w;
  assign bus.mem_we     = gnt_we & ~addr_w[IO_SEL_BIT];
  assign bus.io_we      = gnt_we &  addr_w[IO_SEL_BIT];
  assign bus.cpu_rvalid = cpu_rv;
  assign bus.dbg_rvalid = dbg_rv;
  assign bus.cpu_rdata  = cpu_rdata_w;
  assign bus.dbg_rdata  = dbg_rdata_w;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_owner_q  <= OWNER_CPU;
      rd_sel_q    <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (any_gnt) begin
        addr_q  <= addr_w;
        wdata_q <= wdata_w;
      end
      rd_valid_q  <= any_gnt & ~gnt_we;
      rd_owner_q  <= dbg_gnt ? OWNER_DBG : OWNER_CPU;
      rd_sel_q    <= addr_w[IO_SEL_BIT];
      cpu_rdata_q <= cpu_rdata_w;
      dbg_rdata_q <= dbg_rdata_w;
    end
  end

`ifdef MEM_IO_ARB_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_dbg_cnt   <= '0;
    end else begin
      if (stall)
        perf_stall_cnt <= sat_inc32(perf_stall_cnt);
      if (dbg_gnt)
        perf_dbg_cnt <= sat_inc32(perf_dbg_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Directed-vector bench for mem_io_arbiter.
// Inputs change 1ns after clock rise; outputs sampled 1ns later.
module tb_mem_io_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_io_arbiter_if #(.AW(32), .DW(32)) bus_if ();

`ifdef MEM_IO_ARB_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_dbg_cnt;
`endif

  mem_io_arbiter #(
    .AW(32), .DW(32), .MAX_BURST(8)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus_if.slave)
`ifdef MEM_IO_ARB_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_dbg_cnt   (perf_dbg_cnt)
`endif
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus_if.cpu_req   = 1'b0;
    bus_if.cpu_we    = 1'b0;
    bus_if.cpu_addr  = '0;
    bus_if.cpu_wdata = '0;
    bus_if.dbg_req   = 1'b0;
    bus_if.dbg_lock  = 1'b0;
    bus_if.dbg_we    = 1'b0;
    bus_if.dbg_addr  = '0;
    bus_if.dbg_wdata = '0;
  endtask

  logic exp_dg [4];
  logic exp_st [4];

  initial begin
    idle_all();
    bus_if.mem_rdata = '0;
    bus_if.io_rdata  = '0;
    exp_dg = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_st = '{1'b0, 1'b1, 1'b0, 1'b1};

    // reset cycle: write request must be ignored
    cyc();
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_we   = 1'b1;
    bus_if.cpu_addr = 32'h10;
    #1;
    chk("rst_stall", bus_if.cpu_stall, 0);
    chk("rst_mem_we", bus_if.mem_we, 0);
    chk("rst_dbg_gnt", bus_if.dbg_gnt, 0);
    chk("rst_addr", bus_if.bus_addr, 0);
    chk("rst_crv", bus_if.cpu_rvalid, 0);
    chk("rst_drv", bus_if.dbg_rvalid, 0);
    chk("rst_crd", bus_if.cpu_rdata, 0);
    chk("rst_drd", bus_if.dbg_rdata, 0);

    // 1: cpu-only RAM write
    cyc();
    rst = 1'b0;
    bus_if.cpu_wdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_mem_we", bus_if.mem_we, 1);
    chk("t1_io_we", bus_if.io_we, 0);
    chk("t1_stall", bus_if.cpu_stall, 0);
    chk("t1_addr", bus_if.bus_addr, 32'h10);
    chk("t1_wdata", bus_if.bus_wdata, 32'hDEAD_BEEF);

    // 2: cpu I/O read
    cyc();
    bus_if.cpu_we   = 1'b0;
    bus_if.cpu_addr = 32'h80;
    bus_if.io_rdata = 32'h55;
    #1;
    chk("t2_mem_we", bus_if.mem_we, 0);
    chk("t2_io_we", bus_if.io_we, 0);
    chk("t2_addr", bus_if.bus_addr, 32'h80);
    cyc();
    bus_if.cpu_req = 1'b0;
    #1;
    chk("t2_rvalid", bus_if.cpu_rvalid, 1);
    chk("t2_rdata", bus_if.cpu_rdata, 32'h55);
    chk("t2_drv", bus_if.dbg_rvalid, 0);
    chk("t2_hold_addr", bus_if.bus_addr, 32'h80);
    cyc();
    bus_if.io_rdata = 32'h99;
    #1;
    chk("t2_rv_pulse", bus_if.cpu_rvalid, 0);
    chk("t2_rd_hold", bus_if.cpu_rdata, 32'h55);

    // 3: round robin after reset
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus_if.cpu_req = 1'b1;
    bus_if.dbg_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t3_dgnt%0d", i),
          bus_if.dbg_gnt, exp_dg[i]);
      chk($sformatf("t3_stall%0d", i),
          bus_if.cpu_stall, exp_st[i]);
      cyc();
    end
    idle_all();

    // 4: dbg burst lock, forced release after 8
    cyc();
    bus_if.dbg_req  = 1'b1;
    bus_if.dbg_lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) bus_if.cpu_req = 1'b1;
      #1;
      chk($sformatf("t4_dgnt%0d", i),
          bus_if.dbg_gnt, (i != 8));
      chk($sformatf("t4_stall%0d", i),
          bus_if.cpu_stall, (i != 0 && i != 8));
      cyc();
    end
    idle_all();

    // 5: back-to-back reads cpu RAM then dbg I/O
    cyc();
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_addr = 32'h04;
    cyc();
    bus_if.cpu_req   = 1'b0;
    bus_if.dbg_req   = 1'b1;
    bus_if.dbg_addr  = 32'h84;
    bus_if.mem_rdata = 32'h11;
    #1;
    chk("t5_crv", bus_if.cpu_rvalid, 1);
    chk("t5_crd", bus_if.cpu_rdata, 32'h11);
    chk("t5_drv0", bus_if.dbg_rvalid, 0);
    chk("t5_dgnt", bus_if.dbg_gnt, 1);
    cyc();
    bus_if.dbg_req  = 1'b0;
    bus_if.io_rdata = 32'h22;
    #1;
    chk("t5_drv", bus_if.dbg_rvalid, 1);
    chk("t5_drd", bus_if.dbg_rdata, 32'h22);
    chk("t5_crv0", bus_if.cpu_rvalid, 0);
    chk("t5_crd_hold", bus_if.cpu_rdata, 32'h11);
    cyc();
    #1;
    chk("t5_drv_pulse", bus_if.dbg_rvalid, 0);

    // 6: reset while dbg read in flight
    cyc();
    bus_if.dbg_req  = 1'b1;
    bus_if.dbg_addr = 32'h84;
    cyc();
    rst = 1'b1;
    bus_if.dbg_req  = 1'b0;
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_we   = 1'b1;
    bus_if.cpu_addr = 32'h08;
    bus_if.io_rdata = 32'h77;
    #1;
    chk("t6_drv", bus_if.dbg_rvalid, 0);
    chk("t6_mem_we", bus_if.mem_we, 0);
    chk("t6_stall", bus_if.cpu_stall, 0);
    cyc();
    rst = 1'b0;
    bus_if.cpu_req = 1'b0;
    bus_if.cpu_we  = 1'b0;
    #1;
    chk("t6_drv_post", bus_if.dbg_rvalid, 0);
    chk("t6_drd", bus_if.dbg_rdata, 0);
    chk("t6_crd", bus_if.cpu_rdata, 0);
    chk("t6_addr", bus_if.bus_addr, 0);
    chk("t6_wdata", bus_if.bus_wdata, 0);
    chk("t6_dgnt", bus_if.dbg_gnt, 0);
    cyc();
    bus_if.cpu_req = 1'b1;
    bus_if.cpu_we  = 1'b1;
    bus_if.dbg_req = 1'b1;
    bus_if.dbg_we  = 1'b1;
    #1;
    chk("t6_tie_cpu", bus_if.mem_we, 1);
    chk("t6_tie_dgnt", bus_if.dbg_gnt, 0);
    chk("t6_tie_stall", bus_if.cpu_stall, 0);
    cyc();
    idle_all();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
